// File: rtl/machine_log_buffer_if.sv
// Record-capture and reader bundle of the vending-machine event log.
// The producer/reader side uses master; the log buffer uses slave.
interface machine_log_buffer_if #(
  parameter int PARAM_WIDTH = 4,
  parameter int SEQ_WIDTH   = 8,
  parameter int TS_WIDTH    = 16
);
  logic                   log_valid;
  logic [1:0]             log_operator;
  logic                   log_status;
  logic [PARAM_WIDTH-1:0] log_param2;
  logic [PARAM_WIDTH-1:0] log_param3;
  logic [PARAM_WIDTH-1:0] log_param4;

  logic                   rd_valid;
  logic                   rd_ready;
  logic [1:0]             rd_operator;
  logic                   rd_status;
  logic [PARAM_WIDTH-1:0] rd_param2;
  logic [PARAM_WIDTH-1:0] rd_param3;
  logic [PARAM_WIDTH-1:0] rd_param4;
  logic [SEQ_WIDTH-1:0]   rd_seq;
  logic [TS_WIDTH-1:0]    rd_timestamp;

  modport master (
    output log_valid, log_operator, log_status, log_param2, log_param3, log_param4,
    output rd_ready,
    input  rd_valid, rd_operator, rd_status, rd_param2, rd_param3, rd_param4,
    input  rd_seq, rd_timestamp
  );

  modport slave (
    input  log_valid, log_operator, log_status, log_param2, log_param3, log_param4,
    input  rd_ready,
    output rd_valid, rd_operator, rd_status, rd_param2, rd_param3, rd_param4,
    output rd_seq, rd_timestamp
  );
endinterface

// File: rtl/machine_log_buffer.sv
// Circular event log: tagged, sequence-numbered, timestamped records with
// per-operator filtering, drop-newest or overwrite-oldest full policy and flush.
module machine_log_buffer #(
  parameter int DEPTH       = 16,
  parameter int PARAM_WIDTH = 4,
  parameter int SEQ_WIDTH   = 8,
  parameter int TS_WIDTH    = 16,
  parameter int OVERWRITE   = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  machine_log_buffer_if.slave        bus,
  input  logic [3:0]                 op_enable,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [7:0]                 dropped_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [1:0]             op;
    logic                   status;
    logic [PARAM_WIDTH-1:0] p2;
    logic [PARAM_WIDTH-1:0] p3;
    logic [PARAM_WIDTH-1:0] p4;
    logic [SEQ_WIDTH-1:0]   seq;
    logic [TS_WIDTH-1:0]    ts;
  } rec_t;

  rec_t mem [DEPTH];

  logic [AW-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [SEQ_WIDTH-1:0] seq_reg, seq_next;
  logic [TS_WIDTH-1:0]  ts_reg;
  logic [7:0]           dropped_reg, dropped_next;

  logic wr_req, rd_fire, is_full, wr_store, head_adv, drop;
  rec_t wr_rec, head_rec;

  always_comb begin
    wr_req   = bus.log_valid && op_enable[bus.log_operator] && !clear;
    rd_fire  = (count_reg != '0) && bus.rd_ready && !clear;
    is_full  = (count_reg == CW'(DEPTH));
    wr_store = wr_req && (!is_full || rd_fire || (OVERWRITE != 0));
    drop     = wr_req && is_full && !rd_fire;
    // Under overwrite the oldest record is evicted to make room for the new one.
    head_adv = rd_fire || (wr_store && is_full && !rd_fire);

    wr_rec.op     = bus.log_operator;
    wr_rec.status = bus.log_status;
    wr_rec.p2     = bus.log_param2;
    wr_rec.p3     = bus.log_param3;
    wr_rec.p4     = bus.log_param4;
    wr_rec.seq    = seq_reg;
    wr_rec.ts     = ts_reg;

    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    seq_next     = seq_reg;
    dropped_next = dropped_reg;

    if (clear) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      dropped_next = '0;
    end else begin
      if (wr_store) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        seq_next    = seq_reg + SEQ_WIDTH'(1);
      end
      if (head_adv)
        rd_ptr_next = rd_ptr_reg + AW'(1);
      if (wr_store && !head_adv)
        count_next = count_reg + CW'(1);
      else if (head_adv && !wr_store)
        count_next = count_reg - CW'(1);
      if (drop && dropped_reg != 8'hFF)
        dropped_next = dropped_reg + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      seq_reg     <= '0;
      ts_reg      <= '0;
      dropped_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      seq_reg     <= seq_next;
      ts_reg      <= ts_reg + TS_WIDTH'(1);
      dropped_reg <= dropped_next;
    end
  end

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (wr_store)
      mem[wr_ptr_reg] <= wr_rec;
  end

  assign head_rec         = mem[rd_ptr_reg];
  assign bus.rd_valid     = (count_reg != '0);
  assign bus.rd_operator  = head_rec.op;
  assign bus.rd_status    = head_rec.status;
  assign bus.rd_param2    = head_rec.p2;
  assign bus.rd_param3    = head_rec.p3;
  assign bus.rd_param4    = head_rec.p4;
  assign bus.rd_seq       = head_rec.seq;
  assign bus.rd_timestamp = head_rec.ts;

  assign count         = count_reg;
  assign full          = is_full;
  assign empty         = (count_reg == '0);
  assign dropped_count = dropped_reg;
endmodule

// File: tb/tb_machine_log_buffer.sv
// Scoreboard bench: three log buffers (16 drop, 4 drop, 4 overwrite) share the
// record stimulus; per-instance monitors pop expected records on every read.
module tb_machine_log_buffer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       lv;
  logic [1:0] lop;
  logic       lst;
  logic [3:0] lp2, lp3, lp4;
  logic [2:0] sel, rdy, clr;
  logic [3:0] en;

  logic [4:0] cnt_w   [3];
  logic       full_w  [3];
  logic       empty_w [3];
  logic       rv_w    [3];
  logic [7:0] drop_w  [3];
  logic [1:0] hop_w   [3];
  logic [7:0] hseq_w  [3];

  typedef struct {
    logic [1:0]  op;
    logic        st;
    logic [3:0]  p2, p3, p4;
    logic [7:0]  seq;
    logic [15:0] ts;
  } rec_t;

  rec_t exp_q [3][$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] tb_ts;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DEP = (gi == 0) ? 16 : 4;
      localparam int OW  = (gi == 2) ? 1 : 0;

      machine_log_buffer_if #(.PARAM_WIDTH(4), .SEQ_WIDTH(8), .TS_WIDTH(16)) bus ();

      logic [$clog2(DEP+1)-1:0] cnt;
      logic                     fl, em;
      logic [7:0]               dc;

      assign bus.log_valid    = lv & sel[gi];
      assign bus.log_operator = lop;
      assign bus.log_status   = lst;
      assign bus.log_param2   = lp2;
      assign bus.log_param3   = lp3;
      assign bus.log_param4   = lp4;
      assign bus.rd_ready     = rdy[gi];

      machine_log_buffer #(
        .DEPTH(DEP), .PARAM_WIDTH(4), .SEQ_WIDTH(8), .TS_WIDTH(16), .OVERWRITE(OW)
      ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .op_enable    (en),
        .clear        (clr[gi]),
        .count        (cnt),
        .full         (fl),
        .empty        (em),
        .dropped_count(dc)
      );

      assign cnt_w[gi]   = 5'(cnt);
      assign full_w[gi]  = fl;
      assign empty_w[gi] = em;
      assign rv_w[gi]    = bus.rd_valid;
      assign drop_w[gi]  = dc;
      assign hop_w[gi]   = bus.rd_operator;
      assign hseq_w[gi]  = bus.rd_seq;

      always @(negedge clock) begin : mon
        rec_t e;
        if (reset_n && bus.rd_valid && bus.rd_ready) begin
          checks++;
          if (exp_q[gi].size() == 0) begin
            failures++;
            $display("FAIL dut%0d_unexpected_read actual seq=%0d required none", gi, bus.rd_seq);
          end else begin
            e = exp_q[gi].pop_front();
            $display("dut%0d read op=%0d st=%0d p=%0d/%0d/%0d seq=%0d ts=%0d", gi,
                     bus.rd_operator, bus.rd_status, bus.rd_param2, bus.rd_param3,
                     bus.rd_param4, bus.rd_seq, bus.rd_timestamp);
            if (bus.rd_operator !== e.op || bus.rd_status !== e.st ||
                bus.rd_param2 !== e.p2 || bus.rd_param3 !== e.p3 ||
                bus.rd_param4 !== e.p4 || bus.rd_seq !== e.seq ||
                bus.rd_timestamp !== e.ts) begin
              failures++;
              $display("FAIL dut%0d_record actual op=%0d st=%0d p=%0d/%0d/%0d seq=%0d ts=%0d required op=%0d st=%0d p=%0d/%0d/%0d seq=%0d ts=%0d",
                       gi, bus.rd_operator, bus.rd_status, bus.rd_param2, bus.rd_param3,
                       bus.rd_param4, bus.rd_seq, bus.rd_timestamp,
                       e.op, e.st, e.p2, e.p3, e.p4, e.seq, e.ts);
            end
          end
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // One write presented for one cycle; called at posedge+1 so tb_ts is the accept-cycle stamp.
  task automatic wr(input int d, input logic [1:0] op, input logic st,
                    input logic [3:0] p2, input logic [3:0] p3, input logic [3:0] p4,
                    input bit push, input logic [7:0] seq);
    rec_t r;
    sel = 3'(1 << d);
    lv  = 1'b1; lop = op; lst = st; lp2 = p2; lp3 = p3; lp4 = p4;
    if (push) begin
      r.op = op; r.st = st; r.p2 = p2; r.p3 = p3; r.p4 = p4; r.seq = seq; r.ts = tb_ts;
      exp_q[d].push_back(r);
    end
    @(posedge clock); #1;
    lv = 1'b0; sel = '0;
  endtask

  task automatic drain(input int d, input int n);
    rdy[d] = 1'b1;
    repeat (n) @(posedge clock);
    #1 rdy[d] = 1'b0;
  endtask

  initial begin
    lv = 0; lop = 0; lst = 0; lp2 = 0; lp3 = 0; lp4 = 0;
    sel = 0; rdy = 0; clr = 0; en = 4'hF;
    do_reset();

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_count%0d", d), cnt_w[d], 0);
      chk($sformatf("rst_empty%0d", d), empty_w[d], 1);
      chk($sformatf("rst_full%0d", d), full_w[d], 0);
      chk($sformatf("rst_rdvalid%0d", d), rv_w[d], 0);
      chk($sformatf("rst_dropped%0d", d), drop_w[d], 0);
    end

    // Basic capture and in-order drain
    wr(0, 2'd0, 1'b1, 4'd2, 4'd1, 4'd5, 1, 8'd0);
    wr(0, 2'd1, 1'b1, 4'd2, 4'd7, 4'd0, 1, 8'd1);
    wr(0, 2'd2, 1'b1, 4'd9, 4'd0, 4'd0, 1, 8'd2);
    chk("basic_count", cnt_w[0], 3);
    chk("basic_head_op", hop_w[0], 0);
    chk("basic_head_seq", hseq_w[0], 0);
    drain(0, 4);
    chk("basic_empty", empty_w[0], 1);

    // DEPTH=4 drop-newest, then full with simultaneous read and write
    for (int k = 0; k < 6; k++)
      wr(1, 2'd0, 1'b1, 4'(k), 4'd3, 4'd4, k < 4, 8'(k));
    chk("drop_full", full_w[1], 1);
    chk("drop_dropped", drop_w[1], 2);
    chk("drop_count", cnt_w[1], 4);
    rdy[1] = 1'b1;
    wr(1, 2'd3, 1'b0, 4'd11, 4'd12, 4'd13, 1, 8'd4);
    rdy[1] = 1'b0;
    chk("simul_count", cnt_w[1], 4);
    chk("simul_dropped", drop_w[1], 2);
    drain(1, 6);
    chk("drop_empty", empty_w[1], 1);
    clr[1] = 1'b1;
    @(posedge clock); #1 clr[1] = 1'b0;
    chk("clear_dropped_zero", drop_w[1], 0);

    // DEPTH=4 overwrite-oldest: records 0 and 1 are evicted
    for (int k = 0; k < 6; k++)
      wr(2, 2'd2, 1'b1, 4'(k + 1), 4'd0, 4'd0, 1, 8'(k));
    void'(exp_q[2].pop_front());
    void'(exp_q[2].pop_front());
    chk("ow_dropped", drop_w[2], 2);
    chk("ow_count", cnt_w[2], 4);
    chk("ow_full", full_w[2], 1);
    chk("ow_head_seq", hseq_w[2], 2);
    drain(2, 5);

    // Operator filter: charge disabled
    do_reset();
    en = 4'b1101;
    wr(0, 2'd1, 1'b1, 4'd2, 4'd7, 4'd0, 0, 8'd0);
    wr(0, 2'd0, 1'b1, 4'd2, 4'd1, 4'd5, 1, 8'd0);
    chk("filter_count", cnt_w[0], 1);
    chk("filter_dropped", drop_w[0], 0);
    drain(0, 2);
    en = 4'hF;

    // Clear coincident with a write while count=2
    do_reset();
    wr(0, 2'd0, 1'b1, 4'd1, 4'd1, 4'd1, 0, 8'd0);
    wr(0, 2'd0, 1'b1, 4'd2, 4'd2, 4'd2, 0, 8'd1);
    chk("preclear_count", cnt_w[0], 2);
    clr[0] = 1'b1;
    wr(0, 2'd3, 1'b1, 4'd8, 4'd8, 4'd8, 0, 8'd0);
    clr[0] = 1'b0;
    chk("clear_count", cnt_w[0], 0);
    chk("clear_empty", empty_w[0], 1);
    chk("clear_dropped", drop_w[0], 0);
    wr(0, 2'd3, 1'b0, 4'd6, 4'd5, 4'd4, 1, 8'd2);
    drain(0, 2);

    for (int d = 0; d < 3; d++)
      chk($sformatf("leftover_expected%0d", d), exp_q[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/machine_log_buffer.md
# machine_log_buffer

Synthesizable on-chip event log for the vending machine. Buy, charge, receive-money and change-price events are captured as tagged records in a parametrised circular buffer, each stamped with a sequence number and a timestamp. A host-side reader drains records over a valid/ready port. The block is the hardware successor to file-based simulation logging: it adds per-operator filtering, a selectable full policy (drop newest or overwrite oldest), loss counting and flush.

## Interface
- DEPTH, 16, number of record slots; power of two, at least 2
- PARAM_WIDTH, 4, width of each of param2/param3/param4
- SEQ_WIDTH, 8, sequence-number width; wraps modulo 2^SEQ_WIDTH
- TS_WIDTH, 16, free-running timestamp width; wraps modulo 2^TS_WIDTH
- OVERWRITE, 0, full policy: 0 = drop the incoming record, 1 = discard the oldest record
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- log_valid  in  1  an event record is presented this cycle
- log_operator  in  2  00 buy, 01 charge machine, 10 receive money, 11 change price
- log_status  in  1  1 = pass, 0 = error
- log_param2, log_param3, log_param4  in  PARAM_WIDTH each  event parameters; meaning per operator; unused parameters stored as given
- op_enable  in  4  bit k set = records with log_operator==k are logged
- clear  in  1  synchronous flush
- rd_valid  out  1  a record is available (buffer not empty)
- rd_ready  in  1  reader consumes the record at the head
- rd_operator, rd_status, rd_param2..4  out  as input widths  head record fields
- rd_seq  out  SEQ_WIDTH  sequence number of the head record
- rd_timestamp  out  TS_WIDTH  timestamp captured when the head record was written
- count  out  $clog2(DEPTH+1)  records held
- full, empty  out  1  count==DEPTH, count==0
- dropped_count  out  8  records lost to the full policy; saturates at 255

## Operation
- ts: a free-running counter that increments every cycle and wraps.
- Write condition: log_valid && op_enable[log_operator] && !clear. A filtered record (its enable bit is 0) is ignored silently and is not counted as dropped.
- Read condition: rd_valid && rd_ready && !clear.
- Accepted write:
  - Stores {operator, status, params, seq_next, ts} at the write pointer.
  - The write pointer advances.
  - seq_next increments (it starts at 0 after reset).
- Read: the read pointer advances.
- Not full: write and read proceed independently; count changes by +1, -1 or 0.
- Full, read in the same cycle: the write is accepted in the freed slot; count stays DEPTH.
- Full, no read, OVERWRITE=0: the incoming record is discarded; seq_next is unchanged; dropped_count increments.
- Full, no read, OVERWRITE=1: the oldest record is discarded and the new record is stored.
  - Both pointers advance; count stays DEPTH.
  - dropped_count increments; seq_next increments, so the reader sees a gap.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count.
- Head fields are a combinational read of the slot at the read pointer. They are don't-care while rd_valid=0.
- Clear:
  - Empties the buffer (pointers and count go to 0) and zeroes dropped_count.
  - seq_next and ts keep running.
  - A write or read in the same cycle is discarded and not counted.

## Timing
- Reset (reset_n=0, asynchronous): pointers, count, seq_next, ts and dropped_count go to 0. rd_valid=0, empty=1, full=0. Storage contents are not reset.
- Write latency: a record accepted at edge N is visible on rd_* with rd_valid=1 after edge N, provided the buffer was empty.
- A read at edge N presents the next record after edge N, giving 1 record/cycle throughput.
- Timestamp: the value of ts in the accepting cycle, before it increments.
- rd_* fields are stable while rd_valid=1 and rd_ready=0, except under OVERWRITE=1 while full, where the head can advance.
- Reset asserted mid-stream loses all records. After deassertion the first accepted record carries seq 0.

## Test plan
- Reset, then 3 writes (buy pass code 2 count 1 price 5; charge code 2 added 7; receive amount 9) with rd_ready=0 -> count=3, head = buy with seq 0. Draining gives seq 0,1,2 in order with the original fields; empty=1 afterwards.
- DEPTH=4, OVERWRITE=0: 6 writes, no reads -> full=1, dropped_count=2. Reads return seq 0..3.
- DEPTH=4, OVERWRITE=1: 6 writes, no reads -> dropped_count=2. Reads return seq 2,3,4,5.
- Full buffer with simultaneous write and read -> count stays 4, dropped_count unchanged, the new record lands at the tail.
- op_enable=4'b1101 with one charge write and one buy write -> only the buy is stored, with seq 0; dropped_count=0.
- clear asserted together with a write while count=2 -> count=0, empty=1, dropped_count=0. The next accepted record carries seq 2.
